// File: rtl/sram_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sram_queue_scheduler
// Description : Arbitrates the single SRAM command port among NUM_QUEUES
//               logical FIFOs that share one SRAM. Each queue owns a fixed
//               QUEUE_SIZE-word region addressed as {queue_id, pointer}.
//               Grants are bursts of up to BURST_LEN commands. Write and read
//               phases alternate whenever both have work, which limits bus
//               turnarounds. Each phase has its own round-robin pointer.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               wr_req/wr_pop   - input-FIFO has data / pop on write accept
//               rd_req/rd_issue - output side has room / read accepted
//               mem_cmd_*       - valid/ready command port toward SRAM ctrl
//               q_empty/q_full  - registered per-queue occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sram_queue_scheduler #(
    parameter int NUM_QUEUES     = 4,
    parameter int QUEUE_ID_WIDTH = 2,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_NUM_WORDS  = 524288,
    parameter int QUEUE_SIZE     = MEM_NUM_WORDS / NUM_QUEUES,
    parameter int BURST_LEN      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_QUEUES-1:0]     wr_req,
    output logic [NUM_QUEUES-1:0]     wr_pop,
    input  logic [NUM_QUEUES-1:0]     rd_req,
    output logic [NUM_QUEUES-1:0]     rd_issue,
    output logic                      mem_cmd_valid,
    input  logic                      mem_cmd_ready,
    output logic                      mem_cmd_write,
    output logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [QUEUE_ID_WIDTH-1:0] mem_cmd_qid,
    output logic [NUM_QUEUES-1:0]     q_empty,
    output logic [NUM_QUEUES-1:0]     q_full
);

    localparam int c_ptr_w   = MEM_ADDR_WIDTH - QUEUE_ID_WIDTH;
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_burst_w = 8;
    localparam logic [c_cnt_w-1:0]   c_queue_size = c_cnt_w'(QUEUE_SIZE);
    localparam logic [c_burst_w-1:0] c_burst_len  = c_burst_w'(BURST_LEN);
    localparam logic [NUM_QUEUES-1:0] c_one       = {{(NUM_QUEUES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    state_t                      r_state, w_state_nxt;
    logic [QUEUE_ID_WIDTH-1:0]   r_qid, w_qid_nxt;
    logic [c_burst_w-1:0]        r_burst_cnt, w_burst_cnt_nxt;
    logic                        r_last_wr, w_last_wr_nxt;
    logic [QUEUE_ID_WIDTH-1:0]   r_wr_rr, w_wr_rr_nxt;
    logic [QUEUE_ID_WIDTH-1:0]   r_rd_rr, w_rd_rr_nxt;

    logic [c_ptr_w-1:0]          r_wr_ptr [NUM_QUEUES];
    logic [c_ptr_w-1:0]          r_rd_ptr [NUM_QUEUES];
    logic [c_cnt_w-1:0]          r_occ    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]       r_q_empty;
    logic [NUM_QUEUES-1:0]       r_q_full;

    logic [NUM_QUEUES-1:0]       w_wr_elig;
    logic [NUM_QUEUES-1:0]       w_rd_elig;
    logic [QUEUE_ID_WIDTH-1:0]   w_wr_pick;
    logic [QUEUE_ID_WIDTH-1:0]   w_rd_pick;
    logic                        w_burst_wr;
    logic                        w_in_burst;
    logic                        w_cur_elig;
    logic                        w_valid;
    logic                        w_accept;
    logic [c_ptr_w-1:0]          w_cur_ptr;
    logic [c_cnt_w-1:0]          w_occ_upd;
    logic [c_burst_w-1:0]        w_burst_inc;
    logic                        w_limit_hit;

    // First eligible queue at or after 'start', wrapping modulo NUM_QUEUES.
    function automatic logic [QUEUE_ID_WIDTH-1:0] rr_pick(
        input logic [NUM_QUEUES-1:0]     elig,
        input logic [QUEUE_ID_WIDTH-1:0] start
    );
        logic [QUEUE_ID_WIDTH-1:0] idx;
        logic                      found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            idx = start + QUEUE_ID_WIDTH'(i);
            if (!found && elig[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_wr_elig = wr_req & ~r_q_full;
    assign w_rd_elig = rd_req & ~r_q_empty;
    assign w_wr_pick = rr_pick(w_wr_elig, r_wr_rr);
    assign w_rd_pick = rr_pick(w_rd_elig, r_rd_rr);

    assign w_burst_wr  = (r_state == ST_WR_BURST);
    assign w_in_burst  = (r_state == ST_WR_BURST) || (r_state == ST_RD_BURST);
    assign w_cur_elig  = w_burst_wr ? w_wr_elig[r_qid] : w_rd_elig[r_qid];
    assign w_valid     = w_in_burst & w_cur_elig;
    assign w_accept    = w_valid & mem_cmd_ready;
    assign w_cur_ptr   = w_burst_wr ? r_wr_ptr[r_qid] : r_rd_ptr[r_qid];
    assign w_occ_upd   = w_burst_wr ? (r_occ[r_qid] + c_cnt_w'(1))
                                    : (r_occ[r_qid] - c_cnt_w'(1));
    assign w_burst_inc = r_burst_cnt + c_burst_w'(1);

    // The accepted command either exhausts the burst budget or fills/drains
    // the queue; in both cases the queue cannot continue this grant.
    assign w_limit_hit = (w_burst_inc == c_burst_len) ||
                         (w_burst_wr ? (w_occ_upd == c_queue_size)
                                     : (w_occ_upd == '0));

    always_comb begin
        w_state_nxt     = r_state;
        w_qid_nxt       = r_qid;
        w_burst_cnt_nxt = r_burst_cnt;
        w_last_wr_nxt   = r_last_wr;
        w_wr_rr_nxt     = r_wr_rr;
        w_rd_rr_nxt     = r_rd_rr;
        case (r_state)
            ST_IDLE: begin
                // Prefer the opposite phase after a write burst so reads are
                // not starved by a continuously refilled input side.
                if (r_last_wr && (|w_rd_elig)) begin
                    w_state_nxt     = ST_RD_BURST;
                    w_qid_nxt       = w_rd_pick;
                    w_burst_cnt_nxt = '0;
                end else if (|w_wr_elig) begin
                    w_state_nxt     = ST_WR_BURST;
                    w_qid_nxt       = w_wr_pick;
                    w_burst_cnt_nxt = '0;
                end else if (|w_rd_elig) begin
                    w_state_nxt     = ST_RD_BURST;
                    w_qid_nxt       = w_rd_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (w_accept) begin
                    w_burst_cnt_nxt = w_burst_inc;
                end
                if (!w_cur_elig || (w_accept && w_limit_hit)) begin
                    w_state_nxt   = ST_IDLE;
                    w_last_wr_nxt = w_burst_wr;
                    if (w_burst_wr) begin
                        w_wr_rr_nxt = r_qid + QUEUE_ID_WIDTH'(1);
                    end else begin
                        w_rd_rr_nxt = r_qid + QUEUE_ID_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_qid       <= '0;
            r_burst_cnt <= '0;
            r_last_wr   <= 1'b0;
            r_wr_rr     <= '0;
            r_rd_rr     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_qid       <= w_qid_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_last_wr   <= w_last_wr_nxt;
            r_wr_rr     <= w_wr_rr_nxt;
            r_rd_rr     <= w_rd_rr_nxt;
        end
    end

    // Per-queue pointers and occupancy. Only the granted queue can change in
    // a cycle, and only in one direction, so there is never an inc/dec clash.
    // Pointers wrap naturally because QUEUE_SIZE is 2**c_ptr_w.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                r_wr_ptr[q] <= '0;
                r_rd_ptr[q] <= '0;
                r_occ[q]    <= '0;
            end
            r_q_empty <= '1;
            r_q_full  <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (w_accept && (r_qid == QUEUE_ID_WIDTH'(q))) begin
                    if (w_burst_wr) begin
                        r_wr_ptr[q] <= r_wr_ptr[q] + c_ptr_w'(1);
                    end else begin
                        r_rd_ptr[q] <= r_rd_ptr[q] + c_ptr_w'(1);
                    end
                    r_occ[q]     <= w_occ_upd;
                    r_q_empty[q] <= (w_occ_upd == '0);
                    r_q_full[q]  <= (w_occ_upd == c_queue_size);
                end
            end
        end
    end

    assign mem_cmd_valid = w_valid;
    assign mem_cmd_write = w_burst_wr;
    assign mem_cmd_qid   = r_qid;
    assign mem_cmd_addr  = {r_qid, w_cur_ptr};
    assign wr_pop        = (w_accept &&  w_burst_wr) ? (c_one << r_qid) : '0;
    assign rd_issue      = (w_accept && !w_burst_wr) ? (c_one << r_qid) : '0;
    assign q_empty       = r_q_empty;
    assign q_full        = r_q_full;

endmodule
`default_nettype wire

// File: tb/tb_sram_queue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_queue_scheduler
// Description : Self-checking bench. Main instance uses 4 queues of 16 words
//               with bursts of 4; a second instance uses bursts of 1 to show
//               round-robin order. Expected commands are queued when stimulus
//               is applied and compared as the DUT accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_queue_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    always #5 clk = ~clk;

    // main instance (BURST_LEN=4)
    logic [3:0] wr_req = '0, rd_req = '0;
    logic       ready = 1'b1;
    logic [3:0] wr_pop, rd_issue, q_empty, q_full;
    logic       mem_cmd_valid, mem_cmd_write;
    logic [5:0] mem_cmd_addr;
    logic [1:0] mem_cmd_qid;

    // round-robin instance (BURST_LEN=1)
    logic [3:0] wr_req1 = '0, rd_req1 = '0;
    logic       ready1 = 1'b1;
    logic [3:0] wr_pop1, rd_issue1, q_empty1, q_full1;
    logic       valid1, write1;
    logic [5:0] addr1;
    logic [1:0] qid1;

    sram_queue_scheduler #(
        .NUM_QUEUES(4), .QUEUE_ID_WIDTH(2), .MEM_ADDR_WIDTH(6),
        .MEM_NUM_WORDS(64), .QUEUE_SIZE(16), .BURST_LEN(4)
    ) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .wr_pop(wr_pop),
        .rd_req(rd_req), .rd_issue(rd_issue), .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(ready), .mem_cmd_write(mem_cmd_write),
        .mem_cmd_addr(mem_cmd_addr), .mem_cmd_qid(mem_cmd_qid),
        .q_empty(q_empty), .q_full(q_full)
    );

    sram_queue_scheduler #(
        .NUM_QUEUES(4), .QUEUE_ID_WIDTH(2), .MEM_ADDR_WIDTH(6),
        .MEM_NUM_WORDS(64), .QUEUE_SIZE(16), .BURST_LEN(1)
    ) dut1 (
        .clk(clk), .reset(reset), .wr_req(wr_req1), .wr_pop(wr_pop1),
        .rd_req(rd_req1), .rd_issue(rd_issue1), .mem_cmd_valid(valid1),
        .mem_cmd_ready(ready1), .mem_cmd_write(write1),
        .mem_cmd_addr(addr1), .mem_cmd_qid(qid1),
        .q_empty(q_empty1), .q_full(q_full1)
    );

    typedef struct {
        logic [3:0] wr;
        logic       rdy;
        logic       v;
        logic [5:0] a;
        logic [3:0] pop;
        logic [3:0] empty;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [5:0] a;
    } cmd_t;

    vec_t vecs[15];
    cmd_t sb[$];
    cmd_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] wr, input logic rdy, input logic v,
                                input logic [5:0] a, input logic [3:0] pop, input logic [3:0] empty);
        vec_t r;
        r.wr = wr; r.rdy = rdy; r.v = v; r.a = a; r.pop = pop; r.empty = empty;
        return r;
    endfunction

    task automatic push(input logic wr, input int base, input int n);
        cmd_t c;
        for (int i = 0; i < n; i++) begin
            c.wr = wr;
            c.a  = 6'(base + i);
            sb.push_back(c);
        end
    endtask

    // Scoreboard: every accepted command must match the next expectation.
    always @(negedge clk) begin
        if (!reset && mem_cmd_valid && ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=cmd write=%0b addr=%0d required=no command",
                         mem_cmd_write, mem_cmd_addr);
            end else begin
                mon_e = sb.pop_front();
                check("cmd_write", 32'(mem_cmd_write), 32'(mon_e.wr));
                check("cmd_addr", 32'(mem_cmd_addr), 32'(mon_e.a));
                check("cmd_qid", 32'(mem_cmd_qid), 32'(mon_e.a[5:4]));
                check("wr_pop", 32'(wr_pop), mon_e.wr ? 32'(4'b0001 << mon_e.a[5:4]) : 32'd0);
                check("rd_issue", 32'(rd_issue), mon_e.wr ? 32'd0 : 32'(4'b0001 << mon_e.a[5:4]));
            end
        end
    end

    task automatic do_reset();
        reset   = 1'b1;
        wr_req  = '0;
        rd_req  = '0;
        wr_req1 = '0;
        ready   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
    endtask

    // Returns at negedge+1 of the cycle whose accept emptied the scoreboard.
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cycle-by-cycle vectors: burst of 4, idle gap, stall for 3 cycles
        vecs[0]  = mk(4'b0001, 1, 0, 0, 4'b0000, 4'b1111);
        vecs[1]  = mk(4'b0001, 1, 1, 0, 4'b0001, 4'b1111);
        vecs[2]  = mk(4'b0001, 1, 1, 1, 4'b0001, 4'b1110);
        vecs[3]  = mk(4'b0001, 1, 1, 2, 4'b0001, 4'b1110);
        vecs[4]  = mk(4'b0001, 1, 1, 3, 4'b0001, 4'b1110);
        vecs[5]  = mk(4'b0001, 1, 0, 0, 4'b0000, 4'b1110);
        vecs[6]  = mk(4'b0001, 1, 1, 4, 4'b0001, 4'b1110);
        vecs[7]  = mk(4'b0001, 0, 1, 5, 4'b0000, 4'b1110);
        vecs[8]  = mk(4'b0001, 0, 1, 5, 4'b0000, 4'b1110);
        vecs[9]  = mk(4'b0001, 0, 1, 5, 4'b0000, 4'b1110);
        vecs[10] = mk(4'b0001, 1, 1, 5, 4'b0001, 4'b1110);
        vecs[11] = mk(4'b0001, 1, 1, 6, 4'b0001, 4'b1110);
        vecs[12] = mk(4'b0001, 1, 1, 7, 4'b0001, 4'b1110);
        vecs[13] = mk(4'b0000, 1, 0, 0, 4'b0000, 4'b1110);
        vecs[14] = mk(4'b0000, 1, 0, 0, 4'b0000, 4'b1110);

        // ---- write bursts, idle gap and backpressure (table) ----
        do_reset();
        push(1'b1, 0, 8);
        for (int i = 0; i < 15; i++) begin
            wr_req = vecs[i].wr;
            ready  = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("t%0d_valid", i), 32'(mem_cmd_valid), 32'(vecs[i].v));
            check($sformatf("t%0d_wr_pop", i), 32'(wr_pop), 32'(vecs[i].pop));
            check($sformatf("t%0d_q_empty", i), 32'(q_empty), 32'(vecs[i].empty));
            check($sformatf("t%0d_q_full", i), 32'(q_full), 32'd0);
            if (vecs[i].v || i == 0) begin
                check($sformatf("t%0d_addr", i), 32'(mem_cmd_addr), 32'(vecs[i].a));
                check($sformatf("t%0d_qid", i), 32'(mem_cmd_qid), 32'(vecs[i].a[5:4]));
            end
            if (i == 0) begin
                check("t0_write", 32'(mem_cmd_write), 32'd0);
                check("t0_rd_issue", 32'(rd_issue), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        check("table_sb_left", 32'(sb.size()), 32'd0);

        // ---- read burst follows a write burst, then the other write queue ----
        do_reset();
        push(1'b1, 0, 4);
        wr_req = 4'b0001;
        drain("fill_q0", 100);
        @(posedge clk);
        #1;
        wr_req = 4'b0010;
        rd_req = 4'b0001;
        push(1'b0, 0, 4);
        push(1'b1, 16, 4);
        drain("alt_phase", 100);
        @(posedge clk);
        #1;
        wr_req = 4'b0000;
        rd_req = 4'b0000;
        check("alt_q_empty", 32'(q_empty), 32'b1101);
        check("alt_q_full", 32'(q_full), 32'd0);

        // ---- fill q2, hold while full, drain it, refill across the wrap ----
        do_reset();
        push(1'b1, 32, 16);
        wr_req = 4'b0100;
        drain("fill_q2", 200);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_blocks_valid", 32'(mem_cmd_valid), 32'd0);
            check("full_flag", 32'(q_full), 32'b0100);
        end
        @(posedge clk);
        #1;
        wr_req = 4'b0000;
        push(1'b0, 32, 16);
        rd_req = 4'b0100;
        drain("empty_q2", 200);
        @(posedge clk);
        #1;
        rd_req = 4'b0000;
        check("drained_q_empty", 32'(q_empty), 32'b1111);
        check("drained_q_full", 32'(q_full), 32'd0);
        push(1'b1, 32, 16);
        wr_req = 4'b0100;
        drain("wrap_q2", 200);
        @(posedge clk);
        #1;
        wr_req = 4'b0000;
        check("wrap_q_full", 32'(q_full), 32'b0100);

        // ---- round-robin order with single-command bursts ----
        do_reset();
        wr_req1 = 4'b1111;
        begin
            int got = 0;
            int n = 0;
            while (got < 5 && n < 100) begin
                @(negedge clk);
                n++;
                if (valid1 && ready1) begin
                    check($sformatf("rr%0d_qid", got), 32'(qid1), 32'(got % 4));
                    check($sformatf("rr%0d_addr", got), 32'(addr1), 32'((got % 4) * 16 + got / 4));
                    check($sformatf("rr%0d_pop", got), 32'(wr_pop1), 32'(4'b0001 << (got % 4)));
                    got++;
                end
            end
            check("rr_count", 32'(got), 32'd5);
        end
        wr_req1 = 4'b0000;

        // ---- reset pulse in the middle of a write burst ----
        do_reset();
        push(1'b1, 0, 2);
        wr_req = 4'b0001;
        drain("pre_rst", 100);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(mem_cmd_valid), 32'd0);
        check("rst_mid_q_empty", 32'(q_empty), 32'b1111);
        check("rst_mid_wr_pop", 32'(wr_pop), 32'd0);
        push(1'b1, 0, 4);
        drain("post_rst", 100);
        @(posedge clk);
        #1;
        wr_req = 4'b0000;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
